fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
Instruction-fetch control stage directly upstream of the word-indexed, registered instruction memory. Owns the program counter, drives the memory's pc input, and tracks which pc and validity belong to the instruction word the memory presents each cycle. Applies stall, branch and jump redirects resolved in decode, and squashes the wrong-path fetch on a redirect. Output feeds the decode stage alongside the memory's inst word.

Parameters:
ADDR_W, 7, word-address bits actually used (instruction memory depth = 2**ADDR_W = 128)
RESET_PC, 0, word address loaded on reset

Ports:
clk  input  1  rising-edge clock, shared with instruction memory
rst  input  1  asynchronous, active-high reset
stall  input  1  hold pc, inst_pc and inst_valid
branch_taken  input  1  taken conditional branch for the instruction at inst_pc
branch_offset  input  16  signed word offset (instruction imm field)
jump  input  1  unconditional jump for the instruction at inst_pc
jump_target  input  26  jump index field (word address)
pc  output  32  word address to instruction memory; bits [31:ADDR_W] always 0
inst_pc  output  32  word address of the inst word currently out of instruction memory
inst_valid  output  1  inst word currently out of instruction memory is architecturally valid
redirect  output  1  combinational: redirect accepted this cycle (jump or branch_taken, stall low)

Behaviour:
- Reset (async, any time, including mid-redirect): pc=RESET_PC, inst_pc=0, inst_valid=0. All state clears immediately; no pending redirect survives.
- Memory timing: on each rising edge the memory latches memdata[pc]. Therefore after edge N, inst = memdata[pc before N]. The unit registers inst_pc <= pc on the same edge, so inst_pc always labels inst. Latency from pc to inst is 1 cycle.
- next-pc selection, in priority order:
  - stall=1: pc, inst_pc and inst_valid hold. jump and branch_taken are ignored; decode must hold them until stall drops. The memory re-latches the same word, which is harmless.
  - jump=1: pc <= {(inst_pc+1)[31:26], jump_target}, truncated to ADDR_W.
  - branch_taken=1: pc <= inst_pc + 1 + sign_extend(branch_offset), truncated to ADDR_W.
  - Otherwise: pc <= pc + 1.
- jump and branch_taken both high: jump wins.
- inst_valid update, when not stalled:
  - Redirect edge: inst_valid <= 0, because the word latched is the wrong-path memdata[pc].
  - Otherwise: inst_valid <= 1.
  - Redirect inputs are honoured only while inst_valid=1. When inst_valid=0 they are ignored and pc increments.
- Wrap-around: all pc arithmetic is modulo 2**ADDR_W. pc=127 increments to 0. A branch from inst_pc=0 with offset -2 targets 127.
- First fetch after reset release:
  - cycle 0: pc=0, inst_valid=0.
  - after edge 1: inst=memdata[0], inst_pc=0, inst_valid=1, pc=1.
- redirect = ~stall & inst_valid & (jump | branch_taken).

Decomposition:
- Shared package mips_pkg holds:
  - ADDR_W and RESET_PC defaults.
  - Instruction field slice constants (imm [15:0], target [25:0]).
  - Opcode constants for J (000010), BEQ (000100) and BNE (000101), used by the decode-side generator of jump and branch_taken.
- One combinational sub-module is natural: next_pc_calc. Inputs are pc, inst_pc, offset, target and the select signals; output is next pc. The pc and valid registers stay in fetch_pc_unit.

Test Plan:
- Reset release, no stall, 5 edges -> pc sequence 0,1,2,3,4,5; inst_pc 0..4; inst_valid 0 then 1 from edge 1.
- At inst_pc=3, branch_taken=1, offset=+4 -> next pc=8; inst_valid=0 for one cycle; then inst_pc=8, inst_valid=1.
- At inst_pc=6, jump=1, jump_target=26'd2 -> pc=2; the branch_taken asserted in the same cycle is ignored; the squash bubble is observed.
- stall high 3 cycles at pc=4 with branch_taken=1 -> pc, inst_pc and inst_valid frozen; redirect=0; the branch is taken on the first unstalled edge.
- pc=127, free run -> pc=0 next; branch at inst_pc=0 with offset=16'hFFFE -> pc=127.
- rst asserted mid-cycle on a redirect cycle -> pc=0 and inst_valid=0 immediately (before the next edge); the redirect is lost.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch/decode constants: address width, reset pc, instruction fields, opcodes.
// Latency: none (declarations only).
// Backpressure: none.
package mips_pkg;

    localparam int DEFAULT_ADDR_W   = 7;
    localparam int DEFAULT_RESET_PC = 0;

    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int TGT_MSB = 25;
    localparam int TGT_LSB = 0;

    // Opcodes the decode stage matches to raise jump / branch_taken.
    localparam logic [5:0] OPC_J   = 6'b000010;
    localparam logic [5:0] OPC_BEQ = 6'b000100;
    localparam logic [5:0] OPC_BNE = 6'b000101;

    typedef enum logic [1:0] {
        PC_SEL_SEQ    = 2'd0,
        PC_SEL_BRANCH = 2'd1,
        PC_SEL_JUMP   = 2'd2
    } pc_sel_e;

    function automatic logic [31:0] sext16(input logic [15:0] val);
        return {{16{val[15]}}, val};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_next_pc_calc.sv
// Next-pc mux: sequential, pc-relative branch, or pseudo-direct jump; modulo 2**ADDR_W.
// Latency: purely combinational.
// Backpressure: none; stall is applied by the caller.
module next_pc_calc
    import mips_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] inst_pc_in,
    input  logic [15:0]       offset,
    input  logic [25:0]       target,
    input  pc_sel_e           sel,
    output logic [ADDR_W-1:0] next_pc
);

    logic [31:0] seq_inst_pc;

    always_comb begin
        seq_inst_pc = 32'(inst_pc_in) + 32'd1;
        next_pc     = ADDR_W'(pc_in + 1'b1);
        unique case (sel)
            PC_SEL_JUMP:   next_pc = ADDR_W'({seq_inst_pc[31:26], target});
            PC_SEL_BRANCH: next_pc = ADDR_W'(seq_inst_pc + sext16(offset));
            default:       next_pc = ADDR_W'(pc_in + 1'b1);
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch pc owner: drives imem pc, labels the registered inst word with inst_pc/inst_valid.
// Latency: pc to inst one cycle; redirect costs one squashed (inst_valid=0) cycle.
// Backpressure: stall freezes pc, inst_pc and inst_valid; redirects ignored while stalled.
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] pc,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic        redirect
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic [ADDR_W-1:0] next_pc;
    pc_sel_e           pc_sel;

    // A squashed word must not steer fetch, so redirects need inst_valid.
    assign redirect = ~stall & inst_valid_q & (jump | branch_taken);

    always_comb begin
        pc_sel = PC_SEL_SEQ;
        if (redirect) begin
            pc_sel = jump ? PC_SEL_JUMP : PC_SEL_BRANCH;
        end
    end

    next_pc_calc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_calc (
        .pc_in      (pc_q),
        .inst_pc_in (inst_pc_q),
        .offset     (branch_offset),
        .target     (jump_target),
        .sel        (pc_sel),
        .next_pc    (next_pc)
    );

    always_comb begin
        pc_d         = pc_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        if (!stall) begin
            pc_d         = next_pc;
            inst_pc_d    = pc_q;
            // The word latched on a redirect edge is the wrong-path memdata[pc].
            inst_valid_d = ~redirect;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= ADDR_W'(RESET_PC);
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign pc         = {{(32-ADDR_W){1'b0}}, pc_q};
    assign inst_pc    = {{(32-ADDR_W){1'b0}}, inst_pc_q};
    assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: per-cycle expected outputs queued by stimulus, checked by a monitor.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_offset = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_target = '0;
    logic [31:0] pc, inst_pc;
    logic        inst_valid, redirect;

    typedef struct {
        int          step;
        logic [31:0] pc;
        logic [31:0] ipc;
        logic        v;
        logic        r;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    fetch_pc_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc            (pc),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid),
        .redirect      (redirect)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int step, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, step, got, want);
        end
    endtask

    // Monitor: outputs are presented every cycle; sample mid-cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc",         e.step, pc,                 e.pc);
                check("inst_pc",    e.step, inst_pc,            e.ipc);
                check("inst_valid", e.step, {31'd0, inst_valid}, {31'd0, e.v});
                check("redirect",   e.step, {31'd0, redirect},   {31'd0, e.r});
            end
        end
    end

    // One cycle: drive inputs just after the edge, optionally pulse reset mid-cycle,
    // then queue the outputs expected during this cycle.
    task automatic cyc(input logic rst_v, input logic rst_mid, input logic s,
                       input logic b, input logic [15:0] off,
                       input logic j, input logic [25:0] tgt,
                       input logic [31:0] epc, input logic [31:0] eipc,
                       input logic ev, input logic er);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = rst_v;
        stall         = s;
        branch_taken  = b;
        branch_offset = off;
        jump          = j;
        jump_target   = tgt;
        if (rst_mid) begin
            #2;
            rst = 1'b1;
        end
        e.step = step_no;
        e.pc   = epc;
        e.ipc  = eipc;
        e.v    = ev;
        e.r    = er;
        exp_q.push_back(e);
        step_no++;
    endtask

    initial begin
        //   rst mid stl br off      jmp tgt       pc   ipc  v  r
        cyc(1, 0, 0, 0, 16'd0,    0, 26'd0,     0,   0,   0, 0);  // held in reset
        cyc(0, 0, 0, 0, 16'd0,    0, 26'd0,     0,   0,   0, 0);  // cycle 0 after release
        cyc(0, 0, 0, 0, 16'd0,    0, 26'd0,     1,   0,   1, 0);
        cyc(0, 0, 0, 0, 16'd0,    0, 26'd0,     2,   1,   1, 0);
        cyc(0, 0, 0, 0, 16'd0,    0, 26'd0,     3,   2,   1, 0);
        cyc(0, 0, 0, 1, 16'd4,    0, 26'd0,     4,   3,   1, 1);  // branch at inst_pc=3, +4
        cyc(0, 0, 0, 1, 16'd4,    0, 26'd0,     8,   4,   0, 0);  // squashed: branch ignored
        cyc(0, 0, 0, 0, 16'd0,    0, 26'd0,     9,   8,   1, 0);
        cyc(0, 0, 0, 0, 16'd0,    1, 26'd6,     10,  9,   1, 1);  // jump to 6
        cyc(0, 0, 0, 0, 16'd0,    0, 26'd0,     6,   10,  0, 0);
        cyc(0, 0, 0, 1, 16'd5,    1, 26'd2,     7,   6,   1, 1);  // jump beats branch at inst_pc=6
        cyc(0, 0, 0, 0, 16'd0,    0, 26'd0,     2,   7,   0, 0);
        cyc(0, 0, 0, 0, 16'd0,    0, 26'd0,     3,   2,   1, 0);
        cyc(0, 0, 1, 1, 16'd10,   0, 26'd0,     4,   3,   1, 0);  // stall 1 of 3
        cyc(0, 0, 1, 1, 16'd10,   0, 26'd0,     4,   3,   1, 0);
        cyc(0, 0, 1, 1, 16'd10,   0, 26'd0,     4,   3,   1, 0);
        cyc(0, 0, 0, 1, 16'd10,   0, 26'd0,     4,   3,   1, 1);  // taken on first free edge
        cyc(0, 0, 0, 0, 16'd0,    0, 26'd0,     14,  4,   0, 0);
        cyc(0, 0, 0, 0, 16'd0,    1, 26'd126,   15,  14,  1, 1);
        cyc(0, 0, 0, 0, 16'd0,    0, 26'd0,     126, 15,  0, 0);
        cyc(0, 0, 0, 0, 16'd0,    0, 26'd0,     127, 126, 1, 0);
        cyc(0, 0, 0, 0, 16'd0,    0, 26'd0,     0,   127, 1, 0);  // pc wraps 127 -> 0
        cyc(0, 0, 0, 1, 16'hFFFE, 0, 26'd0,     1,   0,   1, 1);  // branch -2 from inst_pc=0
        cyc(0, 0, 0, 0, 16'd0,    0, 26'd0,     127, 1,   0, 0);
        cyc(0, 0, 0, 0, 16'd0,    1, 26'd165,   0,   127, 1, 1);  // target truncated: 165 mod 128
        cyc(0, 0, 0, 0, 16'd0,    0, 26'd0,     37,  0,   0, 0);
        cyc(0, 0, 0, 0, 16'd0,    0, 26'd0,     38,  37,  1, 0);
        cyc(0, 1, 0, 1, 16'd4,    0, 26'd0,     0,   0,   0, 0);  // reset lands mid redirect cycle
        cyc(1, 0, 0, 0, 16'd0,    0, 26'd0,     0,   0,   0, 0);
        cyc(0, 0, 0, 0, 16'd0,    0, 26'd0,     0,   0,   0, 0);
        cyc(0, 0, 0, 0, 16'd0,    0, 26'd0,     1,   0,   1, 0);
        cyc(0, 0, 0, 0, 16'd0,    0, 26'd0,     2,   1,   1, 0);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
